// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - frame constants, error codes and FSM encoding for pattern_cmd_ctrl
package pattern_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_SETLEN = 8'h02;
    localparam logic [7:0] CMD_RUN    = 8'h03;
    localparam logic [7:0] CMD_STOP   = 8'h04;

    localparam logic [1:0] ERR_CHK    = 2'd1;
    localparam logic [1:0] ERR_TMO    = 2'd2;
    localparam logic [1:0] ERR_CMD    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_LEN,
        ST_CHK,
        ST_EXEC
    } state_t;

endpackage

// File: rtl/frame_timeout.sv
// rtl/frame_timeout.sv - inter-byte watchdog: reloads on strobe or when disabled, expires at zero
module frame_timeout #(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || strobe || !en) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign expire = en && !strobe && (cnt == '0);

endmodule

// File: rtl/pattern_cmd_ctrl.sv
// rtl/pattern_cmd_ctrl.sv - parses checksummed UART command frames and drives the pattern generator
module pattern_cmd_ctrl
    import pattern_pkg::*;
#(
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              c_rx,
    input  logic              rst,
    input  logic              rx_flag,
    input  logic [7:0]        rx_byte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W-1:0] pat_len,
    output logic              run,
    output logic              ack,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int unsigned NB = WORD_W / 8;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

    state_t            state;
    logic [7:0]        cmd_q;
    logic [7:0]        chk_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [WORD_W-1:0] data_q;
    logic [BW-1:0]     byte_cnt;
    logic              tmo_en;
    logic              tmo_expire;

    assign tmo_en = (state != ST_IDLE) && (state != ST_EXEC);
    assign busy   = (state != ST_IDLE);

    frame_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (c_rx),
        .rst    (rst),
        .strobe (rx_flag),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    always_ff @(posedge c_rx) begin
        if (rst) begin
            state    <= ST_IDLE;
            cmd_q    <= '0;
            chk_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            data_q   <= '0;
            byte_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            pat_len  <= '0;
            run      <= 1'b0;
            ack      <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            wr_en <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rx_flag && rx_byte == SYNC_BYTE) begin
                        state <= ST_CMD;
                        chk_q <= '0;
                    end
                end

                ST_CMD: begin
                    if (rx_flag) begin
                        cmd_q <= rx_byte;
                        chk_q <= rx_byte;
                        case (rx_byte)
                            CMD_WRITE:         state <= ST_ADDR;
                            CMD_SETLEN:        state <= ST_LEN;
                            CMD_RUN, CMD_STOP: state <= ST_CHK;
                            default: begin
                                state    <= ST_IDLE;
                                err      <= 1'b1;
                                err_code <= ERR_CMD;
                            end
                        endcase
                    end
                end

                ST_ADDR: begin
                    if (rx_flag) begin
                        addr_q   <= rx_byte[ADDR_W-1:0];
                        chk_q    <= chk_q ^ rx_byte;
                        byte_cnt <= '0;
                        state    <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (rx_flag) begin
                        // MS byte arrives first, so shift left and append.
                        data_q   <= WORD_W'({data_q, rx_byte});
                        chk_q    <= chk_q ^ rx_byte;
                        byte_cnt <= byte_cnt + BW'(1);
                        if (byte_cnt == LAST_BYTE) begin
                            state <= ST_CHK;
                        end
                    end
                end

                ST_LEN: begin
                    if (rx_flag) begin
                        len_q <= rx_byte[ADDR_W-1:0];
                        chk_q <= chk_q ^ rx_byte;
                        state <= ST_CHK;
                    end
                end

                ST_CHK: begin
                    if (rx_flag) begin
                        if (rx_byte != chk_q) begin
                            state    <= ST_IDLE;
                            err      <= 1'b1;
                            err_code <= ERR_CHK;
                        end else begin
                            // Actions are registered here so they are visible during EXEC.
                            state <= ST_EXEC;
                            case (cmd_q)
                                CMD_WRITE: begin
                                    if (run) begin
                                        err      <= 1'b1;
                                        err_code <= ERR_CMD;
                                    end else begin
                                        wr_en   <= 1'b1;
                                        wr_addr <= addr_q;
                                        wr_data <= data_q;
                                        ack     <= 1'b1;
                                    end
                                end
                                CMD_SETLEN: begin
                                    if (run) begin
                                        err      <= 1'b1;
                                        err_code <= ERR_CMD;
                                    end else begin
                                        pat_len <= len_q;
                                        ack     <= 1'b1;
                                    end
                                end
                                CMD_RUN: begin
                                    run <= 1'b1;
                                    ack <= 1'b1;
                                end
                                default: begin
                                    run <= 1'b0;
                                    ack <= 1'b1;
                                end
                            endcase
                        end
                    end
                end

                ST_EXEC: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase

            if (tmo_expire) begin
                state    <= ST_IDLE;
                err      <= 1'b1;
                err_code <= ERR_TMO;
            end
        end
    end

endmodule

// File: tb/tb_pattern_cmd_ctrl.sv
// tb/tb_pattern_cmd_ctrl.sv - directed vectors, corner sequences and randomized frames vs a frame-level model
module tb_pattern_cmd_ctrl;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 8;
    localparam int TMO    = 50;
    localparam int NB     = WORD_W / 8;

    logic              c_rx = 1'b0;
    logic              rst;
    logic              rx_flag;
    logic [7:0]        rx_byte;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic [ADDR_W-1:0] pat_len;
    logic              run;
    logic              ack;
    logic              err;
    logic [1:0]        err_code;
    logic              busy;

    pattern_cmd_ctrl #(
        .WORD_W      (WORD_W),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .c_rx     (c_rx),
        .rst      (rst),
        .rx_flag  (rx_flag),
        .rx_byte  (rx_byte),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .pat_len  (pat_len),
        .run      (run),
        .ack      (ack),
        .err      (err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 c_rx = ~c_rx;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int          n;
        logic [63:0] b;
        logic        ack;
        logic        err;
        logic [1:0]  code;
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [7:0]  len;
        logic        run;
        logic        busy;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   both_cnt = 0;
    int   wr_cnt   = 0;
    logic mon_en   = 1'b0;

    logic        m_run;
    logic [7:0]  m_len;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    logic [1:0]  m_code;
    logic        e_ack, e_err, e_wr, e_busy;

    always @(negedge c_rx) begin
        if (ack && err) both_cnt++;
        if (mon_en && wr_en) wr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_rx);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_flag = 1'b1;
        tick();
        rx_flag = 1'b0;
    endtask

    task automatic send_frame(input bq_t q);
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i]);
            if (i < q.size() - 1) repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    function automatic vec_t mkv(input int n, input logic [63:0] b, input logic a, input logic e,
                                 input logic [1:0] c, input logic w, input logic [7:0] ad,
                                 input logic [15:0] d, input logic [7:0] l, input logic r,
                                 input logic bz);
        vec_t v;
        v.n = n; v.b = b; v.ack = a; v.err = e; v.code = c; v.wr = w;
        v.addr = ad; v.data = d; v.len = l; v.run = r; v.busy = bz;
        return v;
    endfunction

    // Frame-level reference: decides the outcome of a whole frame from its bytes.
    task automatic model_frame(input bq_t q);
        logic [7:0] x;
        int         last;
        e_ack = 0; e_err = 0; e_wr = 0; e_busy = 0;
        last = q.size() - 1;
        if (!(q[1] inside {8'h01, 8'h02, 8'h03, 8'h04})) begin
            e_err = 1; m_code = 2'd3;
            return;
        end
        x = 8'h00;
        for (int i = 1; i < last; i++) x ^= q[i];
        if (q[last] != x) begin
            e_err = 1; m_code = 2'd1;
            return;
        end
        e_busy = 1;
        case (q[1])
            8'h01: begin
                if (m_run) begin
                    e_err = 1; m_code = 2'd3;
                end else begin
                    e_wr = 1; e_ack = 1;
                    m_addr = q[2];
                    m_data = '0;
                    for (int i = 0; i < NB; i++) m_data = (m_data << 8) | 16'(q[3+i]);
                end
            end
            8'h02: begin
                if (m_run) begin
                    e_err = 1; m_code = 2'd3;
                end else begin
                    e_ack = 1; m_len = q[2];
                end
            end
            8'h03: begin e_ack = 1; m_run = 1; end
            default: begin e_ack = 1; m_run = 0; end
        endcase
    endtask

    task automatic check_model();
        check("rnd_ack",      ack,      e_ack);
        check("rnd_err",      err,      e_err);
        check("rnd_err_code", err_code, m_code);
        check("rnd_wr_en",    wr_en,    e_wr);
        check("rnd_wr_addr",  wr_addr,  m_addr);
        check("rnd_wr_data",  wr_data,  m_data);
        check("rnd_pat_len",  pat_len,  m_len);
        check("rnd_run",      run,      m_run);
        check("rnd_busy",     busy,     e_busy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        int   k;
        bq_t  q;
        logic [7:0] cmd, x, nb;
        int   r;

        vt[0] = mkv(6, 64'hA5010512_34220000, 1, 0, 2'd0, 1, 8'h05, 16'h1234, 8'h00, 0, 1);
        vt[1] = mkv(4, 64'hA5020F0D_00000000, 1, 0, 2'd0, 0, 8'h05, 16'h1234, 8'h0F, 0, 1);
        vt[2] = mkv(3, 64'hA5030300_00000000, 1, 0, 2'd0, 0, 8'h05, 16'h1234, 8'h0F, 1, 1);
        vt[3] = mkv(6, 64'hA50100AA_BB100000, 0, 1, 2'd3, 0, 8'h05, 16'h1234, 8'h0F, 1, 1);
        vt[4] = mkv(3, 64'hA5040000_00000000, 0, 1, 2'd1, 0, 8'h05, 16'h1234, 8'h0F, 1, 0);
        vt[5] = mkv(2, 64'hA57E0000_00000000, 0, 1, 2'd3, 0, 8'h05, 16'h1234, 8'h0F, 1, 0);
        vt[6] = mkv(5, 64'h00FFA504_04000000, 1, 0, 2'd3, 0, 8'h05, 16'h1234, 8'h0F, 0, 1);
        vt[7] = mkv(4, 64'hA5020301_00000000, 1, 0, 2'd3, 0, 8'h05, 16'h1234, 8'h03, 0, 1);
        vt[8] = mkv(6, 64'hA501FF00_00FE0000, 1, 0, 2'd3, 1, 8'hFF, 16'h0000, 8'h03, 0, 1);
        vt[9] = mkv(6, 64'hA501A5A5_A5A40000, 1, 0, 2'd3, 1, 8'hA5, 16'hA5A5, 8'h03, 0, 1);

        rst = 1'b1; rx_flag = 1'b0; rx_byte = 8'h00;
        repeat (3) tick();
        check("rst_wr_en",    wr_en,    0);
        check("rst_wr_addr",  wr_addr,  0);
        check("rst_wr_data",  wr_data,  0);
        check("rst_pat_len",  pat_len,  0);
        check("rst_run",      run,      0);
        check("rst_ack",      ack,      0);
        check("rst_err",      err,      0);
        check("rst_err_code", err_code, 0);
        check("rst_busy",     busy,     0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < vt[v].n; i++) begin
                send_byte(vt[v].b[63-8*i -: 8]);
                if (i < vt[v].n - 1) check($sformatf("v%0d_mid_pulse", v), {ack, err}, 0);
            end
            check($sformatf("v%0d_ack", v),      ack,      vt[v].ack);
            check($sformatf("v%0d_err", v),      err,      vt[v].err);
            check($sformatf("v%0d_err_code", v), err_code, vt[v].code);
            check($sformatf("v%0d_wr_en", v),    wr_en,    vt[v].wr);
            check($sformatf("v%0d_wr_addr", v),  wr_addr,  vt[v].addr);
            check($sformatf("v%0d_wr_data", v),  wr_data,  vt[v].data);
            check($sformatf("v%0d_pat_len", v),  pat_len,  vt[v].len);
            check($sformatf("v%0d_run", v),      run,      vt[v].run);
            check($sformatf("v%0d_busy", v),     busy,     vt[v].busy);
            tick();
            check($sformatf("v%0d_pulse_width", v), {wr_en, ack, err}, 0);
            tick();
        end

        // Silence after the address byte must time out exactly TMO cycles later.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07);
        k = 0;
        while (!err && k < 200) begin
            tick();
            k++;
        end
        check("tmo_latency",  k,        TMO);
        check("tmo_err_code", err_code, 2);
        tick();
        check("tmo_busy_after", busy, 0);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h05); send_byte(8'h07);
        check("tmo_recover_ack", ack,     1);
        check("tmo_recover_len", pat_len, 8'h05);
        tick(); tick();

        // A byte landing in the expiry cycle must be accepted instead.
        send_byte(8'hA5); send_byte(8'h02);
        repeat (TMO - 1) tick();
        check("race_no_err_before", err, 0);
        send_byte(8'h09);
        check("race_no_err_at_expiry", err, 0);
        send_byte(8'h0B);
        check("race_ack", ack,     1);
        check("race_len", pat_len, 8'h09);
        tick(); tick();

        // Reset inside the data bytes of a WRITE must discard the frame.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h12);
        rst = 1'b1;
        tick();
        check("mid_rst_outputs", {wr_en, wr_addr, wr_data, pat_len, run, ack, err, err_code, busy}, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        send_byte(8'h34); send_byte(8'h22);
        repeat (4) tick();
        mon_en = 1'b0;
        check("mid_rst_no_write", wr_cnt, 0);

        m_run = 0; m_len = 0; m_addr = 0; m_data = 0; m_code = 0;
        for (int f = 0; f < 150; f++) begin
            repeat ($urandom_range(0, 2)) begin
                nb = 8'($urandom_range(0, 255));
                if (nb == 8'hA5) nb = 8'h00;
                send_byte(nb);
                tick();
            end
            q = {8'hA5};
            r = $urandom_range(0, 9);
            if (r <= 2)      cmd = 8'h01;
            else if (r <= 4) cmd = 8'h02;
            else if (r <= 6) cmd = 8'h03;
            else if (r <= 8) cmd = 8'h04;
            else             cmd = 8'($urandom_range(5, 255));
            q.push_back(cmd);
            if (cmd inside {8'h01, 8'h02, 8'h03, 8'h04}) begin
                if (cmd == 8'h01) begin
                    for (int i = 0; i < NB + 1; i++) q.push_back(8'($urandom_range(0, 255)));
                end else if (cmd == 8'h02) begin
                    q.push_back(8'($urandom_range(0, 255)));
                end
                x = 8'h00;
                for (int i = 1; i < q.size(); i++) x ^= q[i];
                if ($urandom_range(0, 4) == 0) x ^= 8'($urandom_range(1, 255));
                q.push_back(x);
            end
            model_frame(q);
            send_frame(q);
            check_model();
            tick();
            check("rnd_pulse_width", {wr_en, ack, err}, 0);
            tick();
        end

        check("ack_err_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_cmd_ctrl.md
Name: pattern_cmd_ctrl

Overview:
Command-frame controller between the UART byte receiver and the word-pattern generator.
- Consumes byte/strobe pairs from the receiver (strobe is a 1-cycle flag).
- Parses framed commands and validates an XOR checksum.
- Drives the pattern-memory write port, the pattern-length register and the run/stop control.
- It is the only block that configures or sequences the pattern generator.

Parameters:
- WORD_W, 16: pattern word width; must be 8, 16, 24 or 32; NB = WORD_W/8 data bytes per word.
- ADDR_W, 8: pattern-memory address width, ≤ 8 (one address byte).
- TIMEOUT_CYC, 1000000: maximum c_rx cycles between consecutive bytes inside a frame.

Ports:
- c_rx  in  1  system clock, shared with the receiver.
- rst  in  1  synchronous reset, active-high.
- rx_flag  in  1  1-cycle strobe: rx_byte is valid.
- rx_byte  in  8  received byte.
- wr_en  out  1  1-cycle pattern-memory write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  WORD_W  write data.
- pat_len  out  ADDR_W  index of the last active pattern word.
- run  out  1  pattern generator enable (level).
- ack  out  1  1-cycle pulse: frame accepted and executed.
- err  out  1  1-cycle pulse: frame rejected.
- err_code  out  2  1 = checksum, 2 = timeout, 3 = bad command or refused-while-running; holds until the next err.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, FSM goes to IDLE, timeout counter cleared.
  - rst mid-frame discards the partial frame; no write or ack occurs.
- Frame format: SYNC 0xA5, CMD, payload, CHK.
  - CHK = XOR of CMD and all payload bytes; SYNC is excluded.
- Commands:
  - 0x01 WRITE: payload ADDR, then NB data bytes, MS byte first.
  - 0x02 SETLEN: payload LEN.
  - 0x03 RUN: no payload.
  - 0x04 STOP: no payload.
- Address and length use the low ADDR_W bits of their byte; upper bits are ignored but still included in CHK.
- States:
  - IDLE: waits for rx_flag with rx_byte==0xA5. Other bytes are ignored silently.
  - CMD: a valid CMD goes to ADDR (WRITE), LEN (SETLEN) or CHK (RUN/STOP). Any other value raises err with code 3 the next cycle and returns to IDLE without waiting for CHK.
  - ADDR: latch address, go to DATA.
  - DATA: shift NB bytes into the word using a byte counter 0..NB-1, then go to CHK.
  - LEN: latch length, go to CHK.
  - CHK: compare rx_byte with the running XOR. Match goes to EXEC; mismatch raises err with code 1 and returns to IDLE.
  - EXEC: one cycle, then IDLE.
- EXEC actions (all in the same cycle, one cycle after the CHK rx_flag):
  - WRITE: if run==0, assert wr_en with the latched wr_addr/wr_data, plus ack. If run==1, no write; err with code 3.
  - SETLEN: if run==0, update pat_len and ack. If run==1, err with code 3 and pat_len unchanged.
  - RUN: set run=1 and ack, even if already running.
  - STOP: set run=0 and ack, always.
- Output timing:
  - wr_addr/wr_data hold their last written values after wr_en drops.
  - ack and err are never asserted together.
- Timeout:
  - The counter resets on every rx_flag and counts in all states except IDLE and EXEC.
  - When it reaches TIMEOUT_CYC-1 with no rx_flag: err with code 2, return to IDLE.
  - An rx_flag in the same cycle as expiry wins: the byte is processed and there is no timeout.
- A SYNC byte appearing mid-frame is treated as ordinary data; there is no resynchronisation except through error or timeout.
- The running XOR is cleared on leaving IDLE.

Decomposition:
- Shared package, pattern_pkg:
  - SYNC_BYTE and the CMD_WRITE/SETLEN/RUN/STOP constants;
  - ERR_CHK/ERR_TMO/ERR_CMD codes;
  - the FSM state encoding.
- One sub-module: frame_timeout, a loadable down-counter with clear-on-strobe and an expire output.
- Everything else lives in pattern_cmd_ctrl.

Test Plan:
- WORD_W=16: bytes A5 01 05 12 34 22 (CHK = 01^05^12^34) → one cycle after the last flag, wr_en=1, wr_addr=0x05, wr_data=0x1234 and ack=1, each for exactly one cycle.
- Bytes A5 02 0F 0D then A5 03 03 → pat_len=0x0F with ack, then run=1 with ack. Next, A5 01 00 AA BB 10 → no wr_en; err=1, err_code=3.
- Checksum error: A5 04 00 → err_code=1; run unchanged; busy=0 afterwards.
- Timeout with TIMEOUT_CYC=50: A5 01 07, then silence → err, err_code=2, 50 cycles after the 0x07 flag. A fresh valid frame then completes normally.
- Unknown command: A5 7E → err_code=3 on the next cycle, FSM in IDLE. Noise bytes 00 FF before a valid A5 04 04 → only the STOP frame acks.
- rst asserted between DATA bytes of a WRITE frame → no wr_en ever. All outputs are 0 the cycle after rst.
